// File: rtl/sr_pq_gen.sv
// Shift-register priority queue: a systolic array of sorted {key,data} cells with the head at cell 0.
// Each cell decides its own next value from its neighbours and whether the new entry beats it.

module sr_pq_cell #(
  parameter int KW        = 4,
  parameter int DW        = 4,
  parameter bit MAX_FIRST = 1'b1,
  parameter bit HEAD      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_ins,
  input  logic             i_rem,
  input  logic [KW+DW-1:0] i_new,
  input  logic             i_nb_prev,
  input  logic             i_nb_next,
  input  logic             i_dn_v,
  input  logic [KW+DW-1:0] i_dn_e,
  input  logic             i_up_v,
  input  logic [KW+DW-1:0] i_up_e,
  output logic             o_v,
  output logic [KW+DW-1:0] o_e,
  output logic             o_nb
);
  logic             r_v;
  logic [KW+DW-1:0] r_e;
  logic             w_v;
  logic [KW+DW-1:0] w_e;
  logic [KW-1:0]    w_nk, w_ck;

  assign w_nk = i_new[KW+DW-1 -: KW];
  assign w_ck = r_e[KW+DW-1 -: KW];
  // Strict compare: an equal key never beats, which queues ties in arrival order.
  assign o_nb = !r_v || (MAX_FIRST ? (w_nk > w_ck) : (w_nk < w_ck));

  always_comb begin
    w_v = r_v;
    w_e = r_e;
    if (i_ins && i_rem) begin
      if (i_nb_next && (HEAD || !o_nb)) begin
        w_v = 1'b1;
        w_e = i_new;
      end else if (!i_nb_next) begin
        w_v = i_up_v;
        w_e = i_up_e;
      end
    end else if (i_ins) begin
      if (o_nb && !i_nb_prev) begin
        w_v = 1'b1;
        w_e = i_new;
      end else if (i_nb_prev) begin
        w_v = i_dn_v;
        w_e = i_dn_e;
      end
    end else if (i_rem) begin
      w_v = i_up_v;
      w_e = i_up_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_v <= 1'b0;
      r_e <= '0;
    end else begin
      r_v <= w_v;
      r_e <= w_e;
    end
  end

  assign o_v = r_v;
  assign o_e = r_e;
endmodule

module sr_pq_gen #(
  parameter int KW        = 4,
  parameter int DW        = 4,
  parameter int DEPTH     = 8,
  parameter bit MAX_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ivalid,
  output logic                       irdy,
  input  logic [KW+DW-1:0]           idata,
  output logic                       ovalid,
  input  logic                       ordy,
  output logic [KW+DW-1:0]           odata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int EW = KW + DW;
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]               r_cnt;
  logic                        w_ins, w_rem;
  logic [DEPTH-1:0]            w_v, w_upv, w_dnv, w_nbp;
  logic [DEPTH:0]              w_nb;
  logic [DEPTH-1:0][EW-1:0]    w_e, w_upe, w_dne;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign ovalid = w_v[0];
  assign odata  = w_e[0];
  assign count  = r_cnt;
  assign irdy   = !full || ordy;
  assign w_ins  = ivalid && irdy;
  assign w_rem  = w_v[0] && ordy;

  // Neighbour buses; past the tail is invalid and is beaten by any new entry.
  assign w_nb[DEPTH]          = 1'b1;
  assign w_nbp                = {w_nb[DEPTH-2:0], 1'b0};
  assign w_upv                = {1'b0, w_v[DEPTH-1:1]};
  assign w_dnv                = {w_v[DEPTH-2:0], 1'b0};
  assign w_upe[DEPTH-1]       = '0;
  assign w_upe[DEPTH-2:0]     = w_e[DEPTH-1:1];
  assign w_dne[0]             = '0;
  assign w_dne[DEPTH-1:1]     = w_e[DEPTH-2:0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    sr_pq_cell #(.KW(KW), .DW(DW), .MAX_FIRST(MAX_FIRST), .HEAD(g == 0)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (flush),
      .i_ins    (w_ins),
      .i_rem    (w_rem),
      .i_new    (idata),
      .i_nb_prev(w_nbp[g]),
      .i_nb_next(w_nb[g+1]),
      .i_dn_v   (w_dnv[g]),
      .i_dn_e   (w_dne[g]),
      .i_up_v   (w_upv[g]),
      .i_up_e   (w_upe[g]),
      .o_v      (w_v[g]),
      .o_e      (w_e[g]),
      .o_nb     (w_nb[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || flush)        r_cnt <= '0;
    else if (w_ins && !w_rem) r_cnt <= r_cnt + CW'(1);
    else if (w_rem && !w_ins) r_cnt <= r_cnt - CW'(1);
  end
endmodule

// File: tb/tb_sr_pq_gen.sv
// Drives a max-first and a min-first queue with shared inputs and compares both against
// arrival-ordered reference lists from which the best key (earliest among ties) is popped.

module tb_sr_pq_gen;
  localparam int KW = 4, DW = 4, DEPTH = 4, EW = 8, CW = 3;

  logic          clk = 1'b0;
  logic          rst, flush, ivalid, ordy;
  logic [EW-1:0] idata;
  logic          irdy_a, ovalid_a, full_a, empty_a;
  logic          irdy_b, ovalid_b, full_b, empty_b;
  logic [EW-1:0] odata_a, odata_b;
  logic [CW-1:0] count_a, count_b;

  int            vectors = 0, miscompares = 0;
  logic [EW-1:0] qa[$], qb[$];
  bit            clean;

  always #5 clk = ~clk;

  sr_pq_gen #(.KW(KW), .DW(DW), .DEPTH(DEPTH), .MAX_FIRST(1'b1)) u_max (
    .clk(clk), .rst(rst), .flush(flush), .ivalid(ivalid), .irdy(irdy_a), .idata(idata),
    .ovalid(ovalid_a), .ordy(ordy), .odata(odata_a), .count(count_a), .full(full_a), .empty(empty_a));

  sr_pq_gen #(.KW(KW), .DW(DW), .DEPTH(DEPTH), .MAX_FIRST(1'b0)) u_min (
    .clk(clk), .rst(rst), .flush(flush), .ivalid(ivalid), .irdy(irdy_b), .idata(idata),
    .ovalid(ovalid_b), .ordy(ordy), .odata(odata_b), .count(count_b), .full(full_b), .empty(empty_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int best(input logic [EW-1:0] qq[$], input bit mx);
    int bi = 0;
    for (int i = 1; i < qq.size(); i++)
      if (mx ? (qq[i][7:4] > qq[bi][7:4]) : (qq[i][7:4] < qq[bi][7:4])) bi = i;
    return bi;
  endfunction

  task automatic check_state(input string t);
    int n = qa.size();
    chk({t, ":cnt_max"}, 32'(count_a), n);
    chk({t, ":cnt_min"}, 32'(count_b), n);
    chk({t, ":ovalid"}, {ovalid_b, ovalid_a}, {2{n > 0}});
    chk({t, ":empty"}, {empty_b, empty_a}, {2{n == 0}});
    chk({t, ":full"}, {full_b, full_a}, {2{n == DEPTH}});
    if (n > 0) begin
      chk({t, ":head_max"}, odata_a, qa[best(qa, 1'b1)]);
      chk({t, ":head_min"}, odata_b, qb[best(qb, 1'b0)]);
    end else if (clean) begin
      chk({t, ":odata_clr"}, {odata_b, odata_a}, 16'h0);
    end
  endtask

  task automatic cyc(input string t, input bit iv, input logic [EW-1:0] d, input bit od,
                     input bit fl = 1'b0, input bit rs = 1'b0);
    int n;
    bit ins, rem;
    ivalid = iv; idata = d; ordy = od; flush = fl; rst = rs;
    #1;
    n = qa.size();
    chk({t, ":irdy"}, {irdy_b, irdy_a}, {2{(n < DEPTH) || od}});
    ins = iv && ((n < DEPTH) || od);
    rem = od && (n > 0);
    @(posedge clk);
    if (rs || fl) begin
      qa.delete(); qb.delete(); clean = 1'b1;
    end else begin
      if (rem) begin
        qa.delete(best(qa, 1'b1));
        qb.delete(best(qb, 1'b0));
      end
      if (ins) begin
        qa.push_back(d); qb.push_back(d); clean = 1'b0;
      end
    end
    #1;
    check_state(t);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ivalid = 1'b0; ordy = 1'b0; idata = '0;
    repeat (2) @(posedge clk);
    #1;
    clean = 1'b1;
    check_state("reset");
    chk("reset:irdy", {irdy_b, irdy_a}, 2'b11);

    // Mixed keys, drained in priority order.
    cyc("t1", 1, 8'h4E, 0); cyc("t1", 1, 8'hCC, 0); cyc("t1", 1, 8'h3D, 0); cyc("t1", 1, 8'h1B, 0);
    chk("t1:hd0", odata_a, 8'hCC); chk("t5:hd0", odata_b, 8'h1B);
    cyc("t1p", 0, 0, 1); chk("t1:hd1", odata_a, 8'h4E); chk("t5:hd1", odata_b, 8'h3D);
    cyc("t1p", 0, 0, 1); chk("t1:hd2", odata_a, 8'h3D); chk("t5:hd2", odata_b, 8'h4E);
    cyc("t1p", 0, 0, 1); chk("t1:hd3", odata_a, 8'h1B); chk("t5:hd3", odata_b, 8'hCC);
    cyc("t1p", 0, 0, 1); chk("t1:empty", empty_a, 1'b1);

    // Full queue: insert blocked without ordy, accepted with it.
    cyc("t2", 1, 8'h91, 0); cyc("t2", 1, 8'h82, 0); cyc("t2", 1, 8'h73, 0); cyc("t2", 1, 8'h64, 0);
    chk("t2:full_irdy", {full_a, irdy_a}, 2'b10);
    cyc("t2drop", 1, 8'hF0, 0); chk("t2:drop_cnt", 32'(count_a), 4);
    cyc("t2swap", 1, 8'hF0, 1); chk("t2:swap_hd", odata_a, 8'hF0); chk("t2:swap_cnt", 32'(count_a), 4);
    cyc("t2fl", 0, 0, 0, 1'b1);

    // Simultaneous insert and remove at partial fill.
    cyc("t3", 1, 8'hC1, 0); cyc("t3", 1, 8'h42, 0); cyc("t3", 1, 8'h33, 0);
    cyc("t3sw", 1, 8'h5F, 1); chk("t3:hd", odata_a, 8'h5F); chk("t3:cnt", 32'(count_a), 3);
    cyc("t3p", 0, 0, 1); chk("t3:hd1", odata_a, 8'h42);
    cyc("t3p", 0, 0, 1); chk("t3:hd2", odata_a, 8'h33);
    cyc("t3fl", 0, 0, 0, 1'b1);

    // Equal keys leave in arrival order.
    cyc("t4", 1, 8'h71, 0); cyc("t4", 1, 8'h72, 0); cyc("t4", 1, 8'h73, 0);
    chk("t4:hd0", {odata_b, odata_a}, 16'h7171);
    cyc("t4p", 0, 0, 1); chk("t4:hd1", {odata_b, odata_a}, 16'h7272);
    cyc("t4p", 0, 0, 1); chk("t4:hd2", {odata_b, odata_a}, 16'h7373);

    // Flush with contents, then reset in the middle of an insert burst.
    cyc("t6", 1, 8'hA5, 0); cyc("t6", 1, 8'h26, 0);
    cyc("t6fl", 1, 8'hE7, 1, 1'b1);
    cyc("t6b", 1, 8'h81, 0); cyc("t6b", 1, 8'h92, 0);
    cyc("t6rst", 1, 8'hF3, 1, 1'b0, 1'b1);
    cyc("t6c", 1, 8'h24, 0); chk("t6:cnt", 32'(count_a), 1);

    // Random traffic; narrow key range in alternate phases to force ties.
    for (int i = 0; i < 800; i++) begin
      logic [EW-1:0] d;
      d = 8'($urandom);
      if (i[6]) d[7:4] = 4'($urandom_range(5, 7));
      cyc("rnd", ($urandom % 10) < 6, d, ($urandom % 2) == 1,
          ($urandom % 60) == 0, ($urandom % 120) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
